// File: rtl/vedic_mult_pipe_if.sv
// vedic_mult_pipe_if: operand/product handshake bundle for vedic_mult_pipe.
//   Parameter WIDTH : operand width in bits (4, 8, 16, 32).
//   in_valid/in_ready : operand pair handshake (in_a, in_b[, in_signed]).
//   out_valid/out_ready : product handshake (out_p, 2*WIDTH bits).
//   in_signed exists only when VEDIC_SIGNED_EN is defined.
//   Modports: master drives operands and out_ready; slave is the multiplier.
interface vedic_mult_pipe_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
`ifdef VEDIC_SIGNED_EN
  logic                 in_signed;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;

`ifdef VEDIC_SIGNED_EN
  modport master (output in_valid, in_a, in_b, in_signed, out_ready,
                  input  in_ready, out_valid, out_p);
  modport slave  (input  in_valid, in_a, in_b, in_signed, out_ready,
                  output in_ready, out_valid, out_p);
`else
  modport master (output in_valid, in_a, in_b, out_ready,
                  input  in_ready, out_valid, out_p);
  modport slave  (input  in_valid, in_a, in_b, out_ready,
                  output in_ready, out_valid, out_p);
`endif
endinterface

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined Vedic (Urdhva-Tiryagbhyam) multiplier.
//   Parameter WIDTH : operand width, one of 4, 8, 16, 32.
//   Ports:
//     clk   : single clock, rising edge.
//     rst_n : synchronous active-low reset.
//     bus   : vedic_mult_pipe_if.slave (in_valid/in_ready/in_a/in_b[/in_signed],
//             out_valid/out_ready/out_p).
//   Pipeline: S1 = four half-width sub-products, S2 = middle sum,
//             S3 = assembled product (out_p).
//   Whole pipeline advances when !out_valid || out_ready; in_ready mirrors that.
//   Optional feature macro: VEDIC_SIGNED_EN adds in_signed; signed operands are
//   multiplied as magnitudes and the product is negated when signs differ.

// Combinational recursive Vedic multiplier, bottoming out in 2x2 cells.
module vedic_mul_comb #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  if (W <= 2) begin : g_cell
    logic t1, t2, c, hh;
    always_comb begin
      t1   = a[1] & b[0];
      t2   = a[0] & b[1];
      c    = t1 & t2;
      hh   = a[1] & b[1];
      p[0] = a[0] & b[0];
      p[1] = t1 ^ t2;
      p[2] = hh ^ c;
      p[3] = hh & c;
    end
  end else begin : g_split
    localparam int H = W / 2;
    logic [W-1:0] ll, lh, hl, hh;

    vedic_mul_comb #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_mul_comb #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
    vedic_mul_comb #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_mul_comb #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));

    always_comb begin
      p = {hh, ll}
        + {{H{1'b0}}, lh, {H{1'b0}}}
        + {{H{1'b0}}, hl, {H{1'b0}}};
    end
  end
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  vedic_mult_pipe_if.slave  bus
);
  localparam int H  = WIDTH / 2;
  localparam int MW = WIDTH + 2;   // middle sum: two cross terms plus carry-in half

  logic advance;

  // Operand magnitudes presented to the sub-multipliers.
  logic [WIDTH-1:0] mag_a, mag_b;

`ifdef VEDIC_SIGNED_EN
  logic neg_a, neg_b, neg_in;
  always_comb begin
    neg_a  = bus.in_signed & bus.in_a[WIDTH-1];
    neg_b  = bus.in_signed & bus.in_b[WIDTH-1];
    neg_in = neg_a ^ neg_b;
    mag_a  = neg_a ? -bus.in_a : bus.in_a;
    mag_b  = neg_b ? -bus.in_b : bus.in_b;
  end
`else
  always_comb begin
    mag_a = bus.in_a;
    mag_b = bus.in_b;
  end
`endif

  // Top-level split into half-width sub-products (each recursive to 2x2).
  logic [WIDTH-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  vedic_mul_comb #(.W(H)) u_ll (.a(mag_a[H-1:0]),     .b(mag_b[H-1:0]),     .p(pp_ll));
  vedic_mul_comb #(.W(H)) u_lh (.a(mag_a[H-1:0]),     .b(mag_b[WIDTH-1:H]), .p(pp_lh));
  vedic_mul_comb #(.W(H)) u_hl (.a(mag_a[WIDTH-1:H]), .b(mag_b[H-1:0]),     .p(pp_hl));
  vedic_mul_comb #(.W(H)) u_hh (.a(mag_a[WIDTH-1:H]), .b(mag_b[WIDTH-1:H]), .p(pp_hh));

  // Stage registers.
  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_ll, s1_lh, s1_hl, s1_hh;
  logic                 s2_valid;
  logic [MW-1:0]        s2_mid;
  logic [H-1:0]         s2_ll_lo;
  logic [WIDTH-1:0]     s2_hh;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   out_p_q;
`ifdef VEDIC_SIGNED_EN
  logic                 s1_neg, s2_neg;
`endif

  logic [MW-1:0]        mid_sum;
  logic [WIDTH-1:0]     hi_sum;
  logic [2*WIDTH-1:0]   prod_mag;
  logic [2*WIDTH-1:0]   out_next;

  // product = ll_lo + (mid << H) + (hh << WIDTH), where
  // mid = lh + hl + ll_hi; the low H bits of mid land directly in the product
  // and the rest folds into the hh half.
  always_comb begin
    mid_sum  = MW'(s1_lh) + MW'(s1_hl) + MW'(s1_ll[WIDTH-1:H]);
    hi_sum   = s2_hh + WIDTH'(s2_mid[MW-1:H]);
    prod_mag = {hi_sum, s2_mid[H-1:0], s2_ll_lo};
`ifdef VEDIC_SIGNED_EN
    out_next = s2_neg ? -prod_mag : prod_mag;
`else
    out_next = prod_mag;
`endif
  end

  always_comb begin
    advance = !out_valid_q || bus.out_ready;
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = out_p_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_ll       <= '0;
      s1_lh       <= '0;
      s1_hl       <= '0;
      s1_hh       <= '0;
      s2_valid    <= 1'b0;
      s2_mid      <= '0;
      s2_ll_lo    <= '0;
      s2_hh       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
`ifdef VEDIC_SIGNED_EN
      s1_neg      <= 1'b0;
      s2_neg      <= 1'b0;
`endif
    end else if (advance) begin
      // in_ready == advance, so in_valid here is exactly the acceptance.
      s1_valid    <= bus.in_valid;
      s1_ll       <= pp_ll;
      s1_lh       <= pp_lh;
      s1_hl       <= pp_hl;
      s1_hh       <= pp_hh;
      s2_valid    <= s1_valid;
      s2_mid      <= mid_sum;
      s2_ll_lo    <= s1_ll[H-1:0];
      s2_hh       <= s1_hh;
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_p_q <= out_next;
      end
`ifdef VEDIC_SIGNED_EN
      s1_neg      <= neg_in;
      s2_neg      <= s1_neg;
`endif
    end
  end
endmodule

// File: doc/vedic_mult_pipe.md
VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values 4, 8, 16, 32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair present on in_a/in_b.
REQ-005 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port in_a  input  WIDTH  multiplicand.
REQ-007 SHALL have port in_b  input  WIDTH  multiplier.
REQ-008 SHALL have port in_signed  input  1  operands are two's complement; present only under VEDIC_SIGNED_EN.
REQ-009 SHALL have port out_valid  output  1  out_p holds a valid product.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_p this cycle.
REQ-011 SHALL have port out_p  output  2*WIDTH  product.

Function
REQ-012 SHALL accept an operand pair on a rising edge where in_valid and in_ready are both 1, and SHALL not accept one otherwise.
REQ-013 SHALL decompose each operand into halves H=WIDTH/2 and form four HxH sub-products: lo*lo, lo_a*hi_b, hi_a*lo_b, hi*hi; each sub-product SHALL be built recursively the same way down to 2x2 cells.
REQ-014 SHALL use three pipeline stages: S1 registers the four sub-products; S2 registers the middle sum (cross terms plus upper half of lo*lo) with its carries; S3 registers out_p.
REQ-015 SHALL present the product with a latency of exactly 3 cycles from acceptance to out_valid=1 when out_ready stays 1.
REQ-016 SHALL compute out_p = in_a*in_b exactly across 2*WIDTH bits, with no truncation or overflow.
REQ-017 SHALL define advance = !out_valid || out_ready; all three stages, valid bits included, SHALL shift only when advance=1.
REQ-018 SHALL drive in_ready = advance combinationally, so a stalled output stalls the whole pipeline with no data lost.
REQ-019 SHALL hold out_p and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL sustain one accepted pair and one delivered product per cycle when in_valid=1 and out_ready=1 continuously.
REQ-021 SHALL carry internal bubbles (stage valid=0) through the stages without compressing them.
REQ-022 SHALL, on a cycle where a product is taken and a new pair is accepted, perform both, with the pipeline shifting once.

Reset
REQ-023 SHALL, while rst_n=0 at a rising edge, clear all stage valid bits, out_valid and out_p to 0, whatever operations are in flight.
REQ-024 SHALL drive in_ready=1 during and immediately after reset, since out_valid=0.
REQ-025 SHALL discard in-flight operations on reset mid-operation, and SHALL produce no output for them after reset deasserts.

Configuration
REQ-026 SHALL support the macro VEDIC_SIGNED_EN.
REQ-027 When VEDIC_SIGNED_EN is defined, SHALL provide in_signed, sampled with the operands; when in_signed=1 the block SHALL multiply magnitudes, pipeline the result sign (sign_a XOR sign_b), and negate the S3 result in two's complement.
REQ-028 When VEDIC_SIGNED_EN is undefined, SHALL omit in_signed and the sign logic, and SHALL treat operands as unsigned only.

Verification
REQ-029 WIDTH=8, reset asserted then released, in_valid=0 -> out_valid=0, out_p=0x0000, in_ready=1.
REQ-030 WIDTH=8, in_a=0xFF, in_b=0xFF accepted at cycle t, out_ready=1 -> out_valid=1 at t+3 with out_p=0xFE01.
REQ-031 WIDTH=8, back-to-back pairs (3,5),(0xA5,0x3C),(0,0xFF), out_ready=0 from cycle 2 to cycle 6 -> in_ready=0 while stalled; outputs 0x000F, 0x26AC, 0x0000 delivered in order, none lost or duplicated.
REQ-032 WIDTH=16, in_a=0xFFFF, in_b=0x0002 -> out_p=0x0001FFFE after 3 cycles; WIDTH=4, 0xF*0xF -> 0xE1.
REQ-033 WIDTH=8, two pairs in flight, rst_n=0 for one cycle -> out_valid stays 0 after reset and no stale product appears.
REQ-034 VEDIC_SIGNED_EN, WIDTH=8, in_signed=1: 0x80*0x80 -> 0x4000; 0x80*0x7F -> 0xC080; in_signed=0: 0x80*0x80 -> 0x4000, 0xFF*0x02 -> 0x01FE.
